// File: rtl/addsub_ksa_pipe.sv
`timescale 1ns / 1ps
// addsub_ksa_pipe
// ----------------
// Pipelined two's-complement adder/subtractor built on a Kogge-Stone
// parallel-prefix carry network. Subtraction is A + ~B + 1. The
// ceil(log2(DATA_WIDTH)) prefix levels are spread over STAGES register
// stages; earlier stages absorb any leftover levels. Each stage carries a
// valid bit and loads whenever it is empty or is being emptied in the same
// cycle, so a full pipeline streams one result per clock with no bubbles.
//
// Optional build macro:
//   ADDSUB_KSA_SAT_EN - when defined, r clamps to the most positive or most
//                       negative value on signed overflow (ovf still 1).
//
// Parameters:
//   DATA_WIDTH - operand/result width, 4..64
//   STAGES     - register stages between input transfer and result, 1..4
//
// Ports:
//   clk        - clock, all state on the rising edge
//   rst_n      - asynchronous active-low reset, clears every stage
//   in_valid   - operand set present
//   in_ready   - operands accepted this cycle
//   op_sub     - 0 = A+B, 1 = A-B (travels with its operands)
//   a, b       - operands, two's complement
//   out_valid  - result present
//   out_ready  - downstream accepts the result
//   r          - result (wrapped, or saturated with ADDSUB_KSA_SAT_EN)
//   cout       - carry out of the MSB (subtract: 1 = no borrow)
//   ovf        - signed overflow (MSB carry-in != MSB carry-out)

module addsub_ksa_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] r,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W       = DATA_WIDTH;
  localparam int LEVELS  = $clog2(W);
  localparam int LV_BASE = LEVELS / STAGES;
  localparam int LV_REM  = LEVELS % STAGES;

  // ---------------------------------------------------------------------
  // Handshake: stage k may load when it, or any stage downstream of it,
  // has a hole, or when the output is being taken this cycle.
  // ---------------------------------------------------------------------
  logic [STAGES-1:0] v_reg;
  logic [STAGES-1:0] adv;

  always_comb begin : p_adv
    logic hole;
    hole = out_ready;
    adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      hole   = hole | ~v_reg[k];
      adv[k] = hole;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_reg[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg <= '0;
    end else begin
      if (adv[0]) v_reg[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) v_reg[k] <= v_reg[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Operand preparation. The carry-in is folded into the bit-0 generate
  // term, so after the full prefix G[i] is exactly the carry out of bit i.
  // ---------------------------------------------------------------------
  logic [W-1:0] b_eff;
  logic [W-1:0] g_init;
  logic [W-1:0] p_init;

  assign b_eff  = op_sub ? ~b : b;
  assign p_init = a ^ b_eff;
  assign g_init = (a & b_eff) | {{(W-1){1'b0}}, op_sub & p_init[0]};

  // Output registers
  logic [W-1:0] r_reg;
  logic         cout_reg;
  logic         ovf_reg;

  assign r    = r_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

  // ---------------------------------------------------------------------
  // Pipeline stages
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int NLV = LV_BASE + ((gi < LV_REM) ? 1 : 0);
    localparam int LV0 = gi * LV_BASE + ((gi < LV_REM) ? gi : LV_REM);

    logic         vin;
    logic         cin_in;
    logic [W-1:0] hs_in;
    logic [W-1:0] gl [0:NLV];
    logic [W-1:0] pl [0:NLV];

    if (gi == 0) begin : g_src
      assign vin    = in_valid;
      assign cin_in = op_sub;
      assign hs_in  = p_init;
      assign gl[0]  = g_init;
      assign pl[0]  = p_init;
    end else begin : g_src
      assign vin    = v_reg[gi-1];
      assign cin_in = g_stage[gi-1].g_pipe.cin_q;
      assign hs_in  = g_stage[gi-1].g_pipe.hs_q;
      assign gl[0]  = g_stage[gi-1].g_pipe.g_q;
      assign pl[0]  = g_stage[gi-1].g_pipe.p_q;
    end

    // Kogge-Stone levels owned by this stage: level L combines each bit
    // with the group 2^L positions below it.
    for (genvar li = 0; li < NLV; li++) begin : g_lvl
      localparam int           DIST   = 1 << (LV0 + li);
      localparam logic [W-1:0] LOMASK = {W{1'b1}} >> (W - DIST);
      assign gl[li+1] = gl[li] | (pl[li] & (gl[li] << DIST));
      assign pl[li+1] = pl[li] & ((pl[li] << DIST) | LOMASK);
    end

    if (gi < STAGES - 1) begin : g_pipe
      logic [W-1:0] g_q;
      logic [W-1:0] p_q;
      logic [W-1:0] hs_q;
      logic         cin_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          g_q   <= '0;
          p_q   <= '0;
          hs_q  <= '0;
          cin_q <= 1'b0;
        end else if (adv[gi] && vin) begin
          g_q   <= gl[NLV];
          p_q   <= pl[NLV];
          hs_q  <= hs_in;
          cin_q <= cin_in;
        end
      end
    end else begin : g_out
      logic [W-1:0] carry;
      logic [W-1:0] sum_w;
      logic [W-1:0] r_next;
      logic         cout_next;
      logic         ovf_next;
      logic         unused_p;

      // Group propagate is no longer needed once every carry is resolved.
      assign unused_p  = &{1'b0, pl[NLV]};

      assign carry     = {gl[NLV][W-2:0], cin_in};
      assign sum_w     = hs_in ^ carry;
      assign cout_next = gl[NLV][W-1];
      assign ovf_next  = gl[NLV][W-1] ^ gl[NLV][W-2];

`ifdef ADDSUB_KSA_SAT_EN
      // On overflow the true (W+1)-bit result's sign equals the carry out,
      // so cout picks which rail to clamp to.
      always_comb begin
        r_next = sum_w;
        if (ovf_next) begin
          r_next = cout_next ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
      end
`else
      assign r_next = sum_w;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_reg    <= '0;
          cout_reg <= 1'b0;
          ovf_reg  <= 1'b0;
        end else if (adv[gi] && vin) begin
          r_reg    <= r_next;
          cout_reg <= cout_next;
          ovf_reg  <= ovf_next;
        end
      end
    end
  end

endmodule
